// File: rtl/rr_arbiter_lock_pkg.sv
// Shared types and helpers for the round-robin lock arbiter.
package rr_arbiter_lock_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // Ceiling log2. Used for elaboration-time widths only.
    function automatic int log2(input int x);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < x) r = i + 1;
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter_lock_pick.sv
// Combinational round-robin winner pick.
// The request vector is doubled and bits below the start pointer are masked in the low copy.
module rr_arbiter_lock_pick
    import rr_arbiter_lock_pkg::*;
#(
    parameter int N  = 4,
    parameter int BW = (N > 1) ? log2(N) : 1
) (
    input  logic [N-1:0]  i_request,
    input  logic [BW-1:0] i_ptr,
    output logic [N-1:0]  o_winner_oh,
    output logic [BW-1:0] o_winner_bin,
    output logic          o_any
);

    logic [2*N-1:0] w_dbl;
    logic           w_found;

    always_comb begin
        w_dbl        = {i_request, i_request};
        o_winner_oh  = '0;
        o_winner_bin = '0;
        w_found      = 1'b0;
        for (int j = 0; j < N; j++)
            if (j < int'(i_ptr)) w_dbl[j] = 1'b0;
        // The first set bit of the masked doubled vector is the winner, folded back mod N.
        for (int k = 0; k < 2*N; k++) begin
            if (!w_found && w_dbl[k]) begin
                w_found = 1'b1;
                if (k < N) begin
                    o_winner_oh[k] = 1'b1;
                    o_winner_bin   = BW'(k);
                end else begin
                    o_winner_oh[k-N] = 1'b1;
                    o_winner_bin     = BW'(k-N);
                end
            end
        end
    end

    assign o_any = |i_request;

endmodule

// File: rtl/rr_arbiter_lock.sv
// N-input round-robin arbiter with packet lock, optional back-to-back re-grant,
// lock timeout, registered one-hot/binary grant and AND-OR data mux.
module rr_arbiter_lock
    import rr_arbiter_lock_pkg::*;
#(
    parameter int N         = 4,
    parameter int DW        = 32,
    parameter int BW        = (N > 1) ? log2(N) : 1,
    parameter int BACK2BACK = 1,
    parameter int TIMEOUT   = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    request,
    input  logic [N-1:0]    tail,
    input  logic [N*DW-1:0] data_in,
    input  logic            out_ready,
    output logic [N-1:0]    grant_oh,
    output logic [BW-1:0]   grant_bin,
    output logic            grant_valid,
    output logic [DW-1:0]   data_out,
    output logic            transfer,
    output logic            timeout_err
);

    localparam int TW = (TIMEOUT > 0) ? log2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TLIM = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

    state_t         r_state, w_state_nxt;
    logic [BW-1:0]  r_ptr, w_ptr_nxt;
    logic [N-1:0]   r_grant_oh, w_grant_oh_nxt;
    logic [BW-1:0]  r_grant_bin, w_grant_bin_nxt;
    logic           r_grant_valid, w_grant_valid_nxt;
    logic [TW-1:0]  r_tcnt, w_tcnt_nxt;
    logic           r_tout_err, w_tout_err_nxt;

    logic [BW-1:0]  w_ptr_inc, w_scan_ptr, w_win_bin;
    logic [N-1:0]   w_win_oh;
    logic           w_any, w_req_g, w_tail_g, w_transfer;

    assign w_req_g    = |(request & r_grant_oh);
    assign w_tail_g   = |(tail & r_grant_oh);
    assign w_transfer = r_grant_valid & out_ready & w_req_g;
    assign w_ptr_inc  = (r_grant_bin == BW'(N - 1)) ? '0 : r_grant_bin + BW'(1);
    // In BUSY the only pick that matters is the back-to-back one, which scans from g+1.
    assign w_scan_ptr = (r_state == ST_BUSY) ? w_ptr_inc : r_ptr;

    rr_arbiter_lock_pick #(.N(N), .BW(BW)) u_pick (
        .i_request    (request),
        .i_ptr        (w_scan_ptr),
        .o_winner_oh  (w_win_oh),
        .o_winner_bin (w_win_bin),
        .o_any        (w_any)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_ptr         <= '0;
            r_grant_oh    <= '0;
            r_grant_bin   <= '0;
            r_grant_valid <= 1'b0;
            r_tcnt        <= '0;
            r_tout_err    <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_ptr         <= w_ptr_nxt;
            r_grant_oh    <= w_grant_oh_nxt;
            r_grant_bin   <= w_grant_bin_nxt;
            r_grant_valid <= w_grant_valid_nxt;
            r_tcnt        <= w_tcnt_nxt;
            r_tout_err    <= w_tout_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_ptr_nxt         = r_ptr;
        w_grant_oh_nxt    = r_grant_oh;
        w_grant_bin_nxt   = r_grant_bin;
        w_grant_valid_nxt = r_grant_valid;
        w_tcnt_nxt        = r_tcnt;
        w_tout_err_nxt    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_grant_oh_nxt    = w_win_oh;
                    w_grant_bin_nxt   = w_win_bin;
                    w_grant_valid_nxt = 1'b1;
                    w_tcnt_nxt        = '0;
                    w_state_nxt       = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (w_transfer && w_tail_g) begin
                    w_ptr_nxt  = w_ptr_inc;
                    w_tcnt_nxt = '0;
                    if (BACK2BACK != 0 && w_any) begin
                        w_grant_oh_nxt  = w_win_oh;
                        w_grant_bin_nxt = w_win_bin;
                    end else begin
                        w_grant_oh_nxt    = '0;
                        w_grant_bin_nxt   = '0;
                        w_grant_valid_nxt = 1'b0;
                        w_state_nxt       = ST_IDLE;
                    end
                end else if (TIMEOUT > 0 && !w_req_g) begin
                    if (r_tcnt == TLIM) begin
                        w_ptr_nxt         = w_ptr_inc;
                        w_grant_oh_nxt    = '0;
                        w_grant_bin_nxt   = '0;
                        w_grant_valid_nxt = 1'b0;
                        w_tcnt_nxt        = '0;
                        w_tout_err_nxt    = 1'b1;
                        w_state_nxt       = ST_IDLE;
                    end else begin
                        w_tcnt_nxt = r_tcnt + TW'(1);
                    end
                end else if (w_req_g) begin
                    w_tcnt_nxt = '0;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        data_out = '0;
        for (int i = 0; i < N; i++)
            data_out = data_out | (data_in[i*DW +: DW] & {DW{r_grant_oh[i]}});
    end

    assign grant_oh    = r_grant_oh;
    assign grant_bin   = r_grant_bin;
    assign grant_valid = r_grant_valid;
    assign transfer    = w_transfer;
    assign timeout_err = r_tout_err;

endmodule

// File: tb/tb_rr_arbiter_lock.sv
// Directed bench: main DUT with back-to-back and an 8-cycle timeout,
// plus a second copy without back-to-back fed the same stimulus.
module tb_rr_arbiter_lock;

    logic         clk, reset, out_ready;
    logic [3:0]   request, tail;
    logic [127:0] data_in;

    logic [3:0]  grant_oh, grant_oh0;
    logic [1:0]  grant_bin, grant_bin0;
    logic        grant_valid, grant_valid0;
    logic [31:0] data_out, data_out0;
    logic        transfer, transfer0;
    logic        timeout_err, timeout_err0;

    int n_chk  = 0;
    int n_fail = 0;

    rr_arbiter_lock #(.N(4), .DW(32), .BACK2BACK(1), .TIMEOUT(8)) dut (
        .clk(clk), .reset(reset), .request(request), .tail(tail), .data_in(data_in),
        .out_ready(out_ready), .grant_oh(grant_oh), .grant_bin(grant_bin),
        .grant_valid(grant_valid), .data_out(data_out), .transfer(transfer),
        .timeout_err(timeout_err)
    );

    rr_arbiter_lock #(.N(4), .DW(32), .BACK2BACK(0), .TIMEOUT(0)) dut0 (
        .clk(clk), .reset(reset), .request(request), .tail(tail), .data_in(data_in),
        .out_ready(out_ready), .grant_oh(grant_oh0), .grant_bin(grant_bin0),
        .grant_valid(grant_valid0), .data_out(data_out0), .transfer(transfer0),
        .timeout_err(timeout_err0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    localparam logic [127:0] DATA0 = {32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};

    initial begin
        reset = 1'b1; request = '0; tail = '0; out_ready = 1'b0; data_in = DATA0;
        #12;
        chk("rst_oh",    64'(grant_oh), 64'h0);
        chk("rst_bin",   64'(grant_bin), 64'h0);
        chk("rst_valid", 64'(grant_valid), 64'h0);
        chk("rst_terr",  64'(timeout_err), 64'h0);
        chk("rst_data",  64'(data_out), 64'h0);
        reset = 1'b0;

        // 1: first grant goes to input 1
        request = 4'b1010;
        tick();
        chk("t1_oh",    64'(grant_oh), 64'h2);
        chk("t1_bin",   64'(grant_bin), 64'h1);
        chk("t1_valid", 64'(grant_valid), 64'h1);
        chk("t1_data",  64'(data_out), 64'hBBBB0001);
        chk("t1_xfer",  64'(transfer), 64'h0);

        // 2: three-flit packet on input 1, then back-to-back to input 3
        out_ready = 1'b1;
        #1 chk("t2_xfer1", 64'(transfer), 64'h1);
        tick();
        chk("t2_lock1", 64'(grant_oh), 64'h2);
        chk("t2_xfer2", 64'(transfer), 64'h1);
        tick();
        chk("t2_lock2", 64'(grant_oh), 64'h2);
        tail = 4'b0010;
        #1 chk("t2_xfer3", 64'(transfer), 64'h1);
        tick();
        chk("t2_b2b_oh",    64'(grant_oh), 64'h8);
        chk("t2_b2b_bin",   64'(grant_bin), 64'h3);
        chk("t2_b2b_valid", 64'(grant_valid), 64'h1);
        chk("t2_nb_valid",  64'(grant_valid0), 64'h0);
        chk("t2_nb_oh",     64'(grant_oh0), 64'h0);

        // 4: backpressure on input 3, data_out follows the live slice
        out_ready = 1'b0; tail = '0;
        for (int i = 0; i < 5; i++) begin
            data_in[96 +: 32] = 32'h50000000 + 32'(i);
            #1;
            chk("t4_xfer", 64'(transfer), 64'h0);
            chk("t4_oh",   64'(grant_oh), 64'h8);
            chk("t4_data", 64'(data_out), 64'h50000000 + 64'(i));
            tick();
        end
        chk("t4_hold", 64'(grant_oh), 64'h8);
        out_ready = 1'b1;
        #1 chk("t4_resume", 64'(transfer), 64'h1);
        tick();
        chk("t4_nontail", 64'(grant_oh), 64'h8);
        data_in = DATA0;

        // 3: wrap from input 3 to input 0, with and without back-to-back
        request = 4'b1000; tail = 4'b1000; out_ready = 1'b1;
        do_reset();
        tick();
        chk("t3_oh",    64'(grant_oh), 64'h8);
        chk("t3_oh_nb", 64'(grant_oh0), 64'h8);
        request = 4'b1001;
        #1 chk("t3_xfer", 64'(transfer), 64'h1);
        tick();
        chk("t3_wrap_oh",   64'(grant_oh), 64'h1);
        chk("t3_wrap_bin",  64'(grant_bin), 64'h0);
        chk("t3_wrap_data", 64'(data_out), 64'hAAAA0000);
        chk("t3_nb_idle",   64'(grant_valid0), 64'h0);
        chk("t3_nb_oh0",    64'(grant_oh0), 64'h0);
        tick();
        chk("t3_nb_oh",    64'(grant_oh0), 64'h1);
        chk("t3_nb_valid", 64'(grant_valid0), 64'h1);

        // 5: timeout after 8 cycles with request[2] low
        request = 4'b0100; tail = '0; out_ready = 1'b1;
        do_reset();
        tick();
        chk("t5_oh", 64'(grant_oh), 64'h4);
        request = 4'b0001;
        #1 chk("t5_xfer", 64'(transfer), 64'h0);
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("t5_wait_valid", 64'(grant_valid), 64'h1);
            chk("t5_wait_terr",  64'(timeout_err), 64'h0);
        end
        tick();
        chk("t5_terr",  64'(timeout_err), 64'h1);
        chk("t5_valid", 64'(grant_valid), 64'h0);
        chk("t5_oh0",   64'(grant_oh), 64'h0);
        chk("t5_bin0",  64'(grant_bin), 64'h0);
        tick();
        chk("t5_terr_pulse", 64'(timeout_err), 64'h0);
        chk("t5_regrant",    64'(grant_oh), 64'h1);

        // 6: async reset mid-packet, then pointer restarts at 0
        #3 reset = 1'b1;
        #1;
        chk("t6_oh",    64'(grant_oh), 64'h0);
        chk("t6_bin",   64'(grant_bin), 64'h0);
        chk("t6_valid", 64'(grant_valid), 64'h0);
        chk("t6_data",  64'(data_out), 64'h0);
        chk("t6_xfer",  64'(transfer), 64'h0);
        reset = 1'b0;
        request = 4'b0100;
        tick();
        chk("t6_oh2",  64'(grant_oh), 64'h4);
        chk("t6_bin2", 64'(grant_bin), 64'h2);

        // tail without request on the granted input is not a release
        request = 4'b0000; tail = 4'b0100;
        tick();
        chk("tail_noreq_oh",    64'(grant_oh), 64'h4);
        chk("tail_noreq_valid", 64'(grant_valid), 64'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
